gsim_ctrl: RTL and testbench

Sequencing controller for the GSIM Gauss-Seidel solver (16 unknowns, banded coefficients 20/-13/6/-1, Q16.16 results). It accepts the 16-sample b stream and drives the b-memory write port. It then issues per-unknown update commands to the multi-cycle update datapath for a programmable number of sweeps, and finally streams the x memory out with `out_valid`. It holds no arithmetic; all data paths run outside it.

---
 rtl/gsim_pkg.sv | 27 ++
 rtl/gsim_mod_cnt.sv | 37 +++
 rtl/gsim_ctrl.sv | 120 ++++++++++++
 tb/tb_gsim_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/gsim_pkg.sv
// Shared constants and types for the GSIM Gauss-Seidel solver controller and datapath.
package gsim_pkg;

  localparam int unsigned N      = 16;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned ITER_W = 8;
  localparam int unsigned FRAC_W = 16;

  // Band coefficients: diagonal, then first, second and third off-diagonals.
  localparam int COEF_D0 = 20;
  localparam int COEF_D1 = -13;
  localparam int COEF_D2 = 6;
  localparam int COEF_D3 = -1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SWEEP = 2'd2,
    S_OUT   = 2'd3
  } state_e;

  // A requested sweep count of zero still runs one sweep.
  function automatic logic [ITER_W-1:0] eff_limit(input logic [ITER_W-1:0] lim);
    return (lim == '0) ? ITER_W'(1) : lim;
  endfunction

endpackage

// File: rtl/gsim_mod_cnt.sv
// Wrapping up-counter with enable, synchronous clear and terminal-count flag.
module gsim_mod_cnt
  import gsim_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_c_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign tc_c_o = (cnt_q == '1);

endmodule

// File: rtl/gsim_ctrl.sv
// GSIM sequencer: loads b samples, issues per-unknown update commands for the
// programmed number of sweeps, then streams the x memory out.
module gsim_ctrl
  import gsim_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_en_i,
  input  logic [ITER_W-1:0] iter_limit_i,
  output logic              b_wr_en_c_o,
  output logic [IDX_W-1:0]  b_wr_addr_o,
  output logic              upd_req_o,
  output logic [IDX_W-1:0]  upd_idx_o,
  output logic              upd_first_o,
  input  logic              upd_ack_i,
  output logic              rd_en_o,
  output logic [IDX_W-1:0]  rd_addr_o,
  output logic              out_valid_o,
  output logic              busy_o
);

  state_e            state_q, state_d;
  logic [ITER_W-1:0] sweep_q, sweep_d;
  logic [ITER_W-1:0] limit_q, limit_d;
  logic              out_valid_q;

  logic              in_sweep, in_out;
  logic              ld_tc, idx_tc, rd_tc;
  logic              idx_adv;

  assign in_sweep = (state_q == S_SWEEP);
  assign in_out   = (state_q == S_OUT);
  assign idx_adv  = in_sweep && upd_ack_i;

  assign b_wr_en_c_o = in_en_i && ((state_q == S_IDLE) || (state_q == S_LOAD));

  gsim_mod_cnt #(.W(IDX_W)) u_load_cnt (
    .clk    (clk),
    .reset  (reset),
    .en_i   (b_wr_en_c_o),
    .clr_i  (in_sweep || in_out),
    .cnt_o  (b_wr_addr_o),
    .tc_c_o (ld_tc)
  );

  gsim_mod_cnt #(.W(IDX_W)) u_idx_cnt (
    .clk    (clk),
    .reset  (reset),
    .en_i   (idx_adv),
    .clr_i  (!in_sweep),
    .cnt_o  (upd_idx_o),
    .tc_c_o (idx_tc)
  );

  gsim_mod_cnt #(.W(IDX_W)) u_rd_cnt (
    .clk    (clk),
    .reset  (reset),
    .en_i   (in_out),
    .clr_i  (!in_out),
    .cnt_o  (rd_addr_o),
    .tc_c_o (rd_tc)
  );

  // Next-state, sweep counter and latched limit.
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    limit_d = limit_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_en_i) begin
          state_d = S_LOAD;
          sweep_d = '0;
          limit_d = eff_limit(iter_limit_i);
        end
      end
      S_LOAD: begin
        if (in_en_i && ld_tc) begin
          state_d = S_SWEEP;
        end
      end
      S_SWEEP: begin
        if (upd_ack_i && idx_tc) begin
          if ((sweep_q + ITER_W'(1)) < limit_q) begin
            sweep_d = sweep_q + ITER_W'(1);
          end else begin
            state_d = S_OUT;
          end
        end
      end
      S_OUT: begin
        if (rd_tc) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sweep_q     <= '0;
      limit_q     <= ITER_W'(1);
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      limit_q     <= limit_d;
      out_valid_q <= in_out;
    end
  end

  assign upd_req_o   = in_sweep;
  assign upd_first_o = in_sweep && (sweep_q == '0);
  assign rd_en_o     = in_out;
  assign out_valid_o = out_valid_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_gsim_ctrl.sv
// Scoreboard bench for gsim_ctrl: expected writes, updates and reads are queued
// when a job starts and consumed as the controller produces them.
module tb_gsim_ctrl;
  import gsim_pkg::*;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_en = 1'b0;
  logic [ITER_W-1:0] iter_limit = '0;
  logic              upd_ack = 1'b0;
  logic              b_wr_en;
  logic [IDX_W-1:0]  b_wr_addr;
  logic              upd_req;
  logic [IDX_W-1:0]  upd_idx;
  logic              upd_first;
  logic              rd_en;
  logic [IDX_W-1:0]  rd_addr;
  logic              out_valid;
  logic              busy;

  gsim_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .in_en_i      (in_en),
    .iter_limit_i (iter_limit),
    .b_wr_en_c_o  (b_wr_en),
    .b_wr_addr_o  (b_wr_addr),
    .upd_req_o    (upd_req),
    .upd_idx_o    (upd_idx),
    .upd_first_o  (upd_first),
    .upd_ack_i    (upd_ack),
    .rd_en_o      (rd_en),
    .rd_addr_o    (rd_addr),
    .out_valid_o  (out_valid),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [IDX_W-1:0] wr_q[$];
  logic [IDX_W-1:0] rd_q[$];
  logic [IDX_W:0]   upd_q[$];

  int ack_period   = 1;
  bit noise        = 1'b0;
  int ov_cnt       = 0;
  int ncyc         = 0;
  int last_wr_cyc  = 0;
  int last_ack_cyc = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Datapath model: ack tied high, or one ack every ack_period cycles.
  initial begin
    int c = 0;
    forever begin
      @(posedge clk); #1;
      c++;
      upd_ack = (ack_period <= 1) ? 1'b1 : ((c % ack_period) == 0);
    end
  end

  // Monitor: consume expectations as the controller acts.
  initial begin
    logic             prev_req = 1'b0;
    logic             prev_rd  = 1'b0;
    logic             hold_v   = 1'b0;
    logic [IDX_W-1:0] hold_idx = '0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (reset) begin
        prev_req = 1'b0;
        prev_rd  = 1'b0;
        hold_v   = 1'b0;
      end else begin
        if (b_wr_en) begin
          last_wr_cyc = ncyc;
          if (wr_q.size() == 0) check_eq("wr_unexpected", 32'(b_wr_en), 32'd0);
          else check_eq("wr_addr", 32'(b_wr_addr), 32'(wr_q.pop_front()));
        end
        if (upd_req && hold_v) check_eq("idx_hold", 32'(upd_idx), 32'(hold_idx));
        if (upd_req && !prev_req) check_eq("req_latency", 32'(ncyc - last_wr_cyc), 32'd1);
        if (rd_en && !prev_rd) check_eq("rd_latency", 32'(ncyc - last_ack_cyc), 32'd1);
        if (upd_req && upd_ack) begin
          last_ack_cyc = ncyc;
          if (upd_q.size() == 0) check_eq("upd_unexpected", 32'(upd_req), 32'd0);
          else check_eq("upd_first_idx", 32'({upd_first, upd_idx}), 32'(upd_q.pop_front()));
        end
        if (rd_en) begin
          if (rd_q.size() == 0) check_eq("rd_unexpected", 32'(rd_en), 32'd0);
          else check_eq("rd_addr", 32'(rd_addr), 32'(rd_q.pop_front()));
        end
        if (out_valid) ov_cnt++;
        hold_v   = upd_req && !upd_ack;
        hold_idx = upd_idx;
        prev_req = upd_req;
        prev_rd  = rd_en;
      end
    end
  end

  task automatic push_job(input int lim);
    int leff;
    leff = (lim == 0) ? 1 : lim;
    for (int i = 0; i < int'(N); i++) begin
      wr_q.push_back(IDX_W'(i));
      rd_q.push_back(IDX_W'(i));
    end
    for (int s = 0; s < leff; s++)
      for (int i = 0; i < int'(N); i++)
        upd_q.push_back({(s == 0), IDX_W'(i)});
  endtask

  // Drive N samples, optionally pausing for gap cycles before sample stall_at.
  task automatic load(input int stall_at, input int gap);
    int sent = 0;
    int g    = gap;
    while (sent < int'(N)) begin
      @(posedge clk); #1;
      if (sent == stall_at && g > 0) begin
        in_en = 1'b0;
        g--;
        @(negedge clk);
        check_eq("gap_no_write", 32'(b_wr_en), 32'd0);
        check_eq("gap_busy_noreq", 32'({busy, upd_req}), 32'h2);
      end else begin
        in_en = 1'b1;
        sent++;
      end
    end
    @(posedge clk); #1;
    in_en = 1'b0;
  endtask

  // Wait for the job to finish; with noise, toggle in_en during SWEEP/OUT,
  // always including the last OUT cycle.
  task automatic wait_done(input int budget);
    int n = 0;
    do begin
      @(posedge clk); #1;
      in_en = noise && (upd_req || rd_en) &&
              (($urandom_range(1, 0) == 1) || (rd_en && rd_addr == IDX_W'(N - 1)));
      @(negedge clk);
      n++;
    end while (busy && n < budget);
    in_en = 1'b0;
    check_eq("job_timeout", 32'(busy), 32'd0);
    @(negedge clk);
    check_eq("wr_left", 32'(wr_q.size()), 32'd0);
    check_eq("upd_left", 32'(upd_q.size()), 32'd0);
    check_eq("rd_left", 32'(rd_q.size()), 32'd0);
    check_eq("out_valid_pulses", 32'(ov_cnt), 32'(N));
    check_eq("idle_after", 32'({busy, out_valid, rd_en, upd_req}), 32'd0);
  endtask

  task automatic run_job(input int lim, input int stall_at, input int gap,
                         input int period, input bit nz);
    ack_period = period;
    noise      = nz;
    ov_cnt     = 0;
    iter_limit = ITER_W'(lim);
    push_job(lim);
    load(stall_at, gap);
    wait_done(20000);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("reset_vals", 32'({b_wr_en, b_wr_addr, upd_req, upd_idx, upd_first,
                                rd_en, rd_addr, out_valid, busy}), 32'd0);

    run_job(3, -1, 0, 1, 1'b0);
    run_job(1, 8, 5, 1, 1'b0);
    run_job(2, -1, 0, 4, 1'b0);
    run_job(0, -1, 0, 1, 1'b0);
    run_job(255, -1, 0, 1, 1'b0);

    // Abort at idx 9 of sweep 1.
    ack_period = 1;
    noise      = 1'b0;
    iter_limit = ITER_W'(3);
    push_job(3);
    load(-1, 0);
    n = 0;
    while (!(upd_req && upd_idx == IDX_W'(9) && !upd_first) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_eq("reach_s1_idx9", 32'({upd_req, upd_first, upd_idx}), 32'h29);
    @(posedge clk); #1;
    reset = 1'b1;
    wr_q.delete();
    upd_q.delete();
    rd_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_eq("abort_reset_vals", 32'({b_wr_en, b_wr_addr, upd_req, upd_idx, upd_first,
                                      rd_en, rd_addr, out_valid, busy}), 32'd0);
    run_job(2, -1, 0, 1, 1'b0);

    run_job(2, -1, 0, 1, 1'b1);
    run_job(1, -1, 0, 2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
